// File: rtl/npu_system_defines.sv
// npu_system_defines: logger snoop request types and the dump entry record.
package npu_system_defines;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 512;
  typedef enum logic [2:0] {
    SNOOP_CORE,
    SNOOP_MEM,
    GET_CORE_EVENTS,
    GET_MEM_EVENTS,
    GET_EVENT_COUNTER
  } log_snoop_req_enum_t;
  typedef log_snoop_req_enum_t log_snoop_req_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] id;
    logic                  is_write;
    logic                  is_read;
    logic                  last;
  } log_dump_entry_t;
endpackage

// File: rtl/npu_logger_snoop_ctrl_if.sv
// npu_logger_snoop_ctrl_if: host command, logger snoop/response and dump stream signals.
interface npu_logger_snoop_ctrl_if;
  import npu_system_defines::*;
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  log_snoop_req_t        cmd_type_i;
  logic [ADDR_WIDTH-1:0] cmd_start_i;
  logic [ADDR_WIDTH-1:0] cmd_count_i;
  logic                  snoop_valid_o;
  log_snoop_req_t        snoop_request_o;
  logic [ADDR_WIDTH-1:0] snoop_addr_o;
  logic                  cl_valid_i;
  logic [ADDR_WIDTH-1:0] cl_req_addr_i;
  logic [DATA_WIDTH-1:0] cl_req_data_i;
  logic [ADDR_WIDTH-1:0] cl_req_id_i;
  logic                  cl_req_is_write_i;
  logic                  cl_req_is_read_i;
  logic                  dump_valid_o;
  logic                  dump_ready_i;
  logic [ADDR_WIDTH-1:0] dump_addr_o;
  logic [DATA_WIDTH-1:0] dump_data_o;
  logic [ADDR_WIDTH-1:0] dump_id_o;
  logic                  dump_is_write_o;
  logic                  dump_is_read_o;
  logic                  dump_last_o;
  logic                  done_o;
  logic                  protocol_err_o;
  modport slave (
    input  cmd_valid_i, cmd_type_i, cmd_start_i, cmd_count_i,
    input  cl_valid_i, cl_req_addr_i, cl_req_data_i, cl_req_id_i, cl_req_is_write_i, cl_req_is_read_i,
    input  dump_ready_i,
    output cmd_ready_o, snoop_valid_o, snoop_request_o, snoop_addr_o,
    output dump_valid_o, dump_addr_o, dump_data_o, dump_id_o, dump_is_write_o, dump_is_read_o, dump_last_o,
    output done_o, protocol_err_o
  );
  modport master (
    output cmd_valid_i, cmd_type_i, cmd_start_i, cmd_count_i,
    output cl_valid_i, cl_req_addr_i, cl_req_data_i, cl_req_id_i, cl_req_is_write_i, cl_req_is_read_i,
    output dump_ready_i,
    input  cmd_ready_o, snoop_valid_o, snoop_request_o, snoop_addr_o,
    input  dump_valid_o, dump_addr_o, dump_data_o, dump_id_o, dump_is_write_o, dump_is_read_o, dump_last_o,
    input  done_o, protocol_err_o
  );
endinterface

// File: rtl/npu_logger_resp_fifo.sv
// npu_logger_resp_fifo: synchronous FIFO of dump entries with full/empty/count.
module npu_logger_resp_fifo import npu_system_defines::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  log_dump_entry_t din,
  output log_dump_entry_t dout,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count
);
  log_dump_entry_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/npu_logger_snoop_ctrl.sv
// npu_logger_snoop_ctrl: drains the core/mem transaction logger into a credit-limited dump stream.
module npu_logger_snoop_ctrl import npu_system_defines::*; #(
  parameter int LOG_SIZE = 512,
  parameter int FIFO_DEPTH = 4
) (
  input logic                    clk,
  input logic                    reset,
  npu_logger_snoop_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  log_snoop_req_t req;
  logic [ADDR_WIDTH-1:0] start, eff_count, issued, received, cmd_count;
  logic is_range, credit, inflight, push, pop, full, empty, err;
  logic [CW-1:0] fifo_count;
  log_dump_entry_t in_entry, head;
  assign is_range = bus.cmd_type_i inside {SNOOP_CORE, SNOOP_MEM};
  assign cmd_count = !is_range ? ADDR_WIDTH'(1)
                   : bus.cmd_count_i > ADDR_WIDTH'(LOG_SIZE) ? ADDR_WIDTH'(LOG_SIZE) : bus.cmd_count_i;
  // a snoop is only issued if its response is guaranteed a FIFO slot
  assign credit = int'(fifo_count) + int'(inflight) < FIFO_DEPTH;
  assign bus.cmd_ready_o = state == IDLE;
  assign bus.snoop_valid_o = state == ISSUE && issued != eff_count && credit;
  assign bus.snoop_request_o = req;
  assign bus.snoop_addr_o = (start + issued) & ADDR_WIDTH'(LOG_SIZE - 1);
  assign bus.done_o = state == DONE;
  assign bus.protocol_err_o = err;
  assign push = bus.cl_valid_i && inflight;
  assign pop = !empty && bus.dump_ready_i;
  assign in_entry = '{bus.cl_req_addr_i, bus.cl_req_data_i, bus.cl_req_id_i,
                      bus.cl_req_is_write_i, bus.cl_req_is_read_i, received == eff_count - 1'b1};
  assign bus.dump_valid_o = !empty;
  assign bus.dump_addr_o = head.addr;
  assign bus.dump_data_o = head.data;
  assign bus.dump_id_o = head.id;
  assign bus.dump_is_write_o = head.is_write;
  assign bus.dump_is_read_o = head.is_read;
  assign bus.dump_last_o = head.last;
  npu_logger_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .reset, .push, .pop, .din(in_entry), .dout(head), .full, .empty, .count(fifo_count)
  );
  // DRAIN exits on the cycle the final entry pops so done follows the last beat directly
  always_comb begin
    state_n = IDLE;
    if (state == IDLE && bus.cmd_valid_i) state_n = cmd_count == '0 ? DONE : ISSUE;
    if (state == ISSUE) state_n = bus.snoop_valid_o && issued + 1'b1 == eff_count ? DRAIN : ISSUE;
    if (state == DRAIN) state_n = received == eff_count && int'(fifo_count) == int'(pop) ? DONE : DRAIN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      req <= SNOOP_CORE;
      start <= '0;
      eff_count <= '0;
      issued <= '0;
      received <= '0;
      inflight <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= bus.snoop_valid_o;
      err <= err || (bus.cl_valid_i && !inflight) || (push && full && !pop);
      if (state == IDLE && bus.cmd_valid_i) begin
        req <= bus.cmd_type_i;
        start <= is_range ? bus.cmd_start_i : '0;
        eff_count <= cmd_count;
        issued <= '0;
        received <= '0;
      end else begin
        issued <= issued + ADDR_WIDTH'(bus.snoop_valid_o);
        received <= received + ADDR_WIDTH'(push);
      end
    end
endmodule

// File: tb/tb_npu_logger_snoop_ctrl.sv
// tb_npu_logger_snoop_ctrl: directed vectors against a behavioural logger responder.
module tb_npu_logger_snoop_ctrl;
  import npu_system_defines::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inject = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int dones = 0;
  int done_cyc = 0;
  int last_cyc = 0;
  logic [31:0] snoop_addr_q[$];
  logic [2:0] snoop_req_q[$];
  int snoop_cyc_q[$];
  logic [31:0] id_q[$];
  logic [31:0] addr_q[$];
  logic [511:0] data_q[$];
  logic last_q[$];
  logic wr_q[$];

  npu_logger_snoop_ctrl_if bus();
  npu_logger_snoop_ctrl #(.LOG_SIZE(512), .FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_id(input log_snoop_req_t r, input logic [31:0] a);
    return r == SNOOP_CORE ? a : r == SNOOP_MEM ? a + 32'd1000 : r == GET_EVENT_COUNTER ? 32'd5 : 32'd7;
  endfunction

  // logger: registered response exactly one cycle after each snoop
  initial begin
    logic pv;
    log_snoop_req_t pr;
    logic [31:0] pa;
    pv = 1'b0;
    pr = SNOOP_CORE;
    pa = '0;
    bus.cl_valid_i = 1'b0;
    bus.cl_req_addr_i = '0;
    bus.cl_req_data_i = '0;
    bus.cl_req_id_i = '0;
    bus.cl_req_is_write_i = 1'b0;
    bus.cl_req_is_read_i = 1'b0;
    forever begin
      @(negedge clk);
      pv = (bus.snoop_valid_o && !reset) || inject;
      pr = bus.snoop_request_o;
      pa = bus.snoop_addr_o;
      @(posedge clk);
      #1;
      bus.cl_valid_i = pv && !reset;
      bus.cl_req_addr_i = pa * 4 + 32'h1000;
      bus.cl_req_data_i = {16{pa ^ 32'hA5A5_0000}};
      bus.cl_req_id_i = model_id(pr, pa);
      bus.cl_req_is_write_i = pa[0];
      bus.cl_req_is_read_i = !pa[0];
    end
  end

  always @(negedge clk) begin
    if (bus.snoop_valid_o) begin
      snoop_addr_q.push_back(bus.snoop_addr_o);
      snoop_req_q.push_back(bus.snoop_request_o);
      snoop_cyc_q.push_back(cyc);
    end
    if (bus.dump_valid_o && bus.dump_ready_i) begin
      id_q.push_back(bus.dump_id_o);
      addr_q.push_back(bus.dump_addr_o);
      data_q.push_back(bus.dump_data_o);
      last_q.push_back(bus.dump_last_o);
      wr_q.push_back(bus.dump_is_write_o);
      last_cyc = cyc;
    end
    if (bus.done_o) begin
      dones++;
      done_cyc = cyc;
    end
  end

  task automatic start_cmd(input log_snoop_req_t t, input int st, input int cnt);
    snoop_addr_q.delete();
    snoop_req_q.delete();
    snoop_cyc_q.delete();
    id_q.delete();
    addr_q.delete();
    data_q.delete();
    last_q.delete();
    wr_q.delete();
    dones = 0;
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_type_i = t;
    bus.cmd_start_i = st;
    bus.cmd_count_i = cnt;
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && dones == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int lasts;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_type_i = SNOOP_CORE;
    bus.cmd_start_i = '0;
    bus.cmd_count_i = '0;
    bus.dump_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready_o, 1);
    chk("rst_snoop_valid", bus.snoop_valid_o, 0);
    chk("rst_snoop_req", bus.snoop_request_o, SNOOP_CORE);
    chk("rst_snoop_addr", bus.snoop_addr_o, 0);
    chk("rst_dump_valid", bus.dump_valid_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_err", bus.protocol_err_o, 0);

    start_cmd(SNOOP_CORE, 0, 3);
    wait_done(100);
    chk("core_snoops", snoop_addr_q.size(), 3);
    for (int i = 0; i < 3 && i < snoop_addr_q.size(); i++) chk("core_snoop_addr", snoop_addr_q[i], i);
    if (snoop_cyc_q.size() == 3) chk("core_snoop_b2b", snoop_cyc_q[2] - snoop_cyc_q[0], 2);
    chk("core_beats", id_q.size(), 3);
    for (int i = 0; i < 3 && i < id_q.size(); i++) begin
      chk("core_id", id_q[i], i);
      chk("core_last", last_q[i], i == 2);
    end
    if (id_q.size() > 1) begin
      chk("core_addr1", addr_q[1], 32'h1004);
      chk("core_data1", data_q[1] == {16{32'hA5A5_0001}}, 1);
      chk("core_wr1", wr_q[1], 1);
    end
    chk("core_dones", dones, 1);
    chk("core_done_lat", done_cyc - last_cyc, 1);
    chk("core_ready_after", bus.cmd_ready_o, 1);

    start_cmd(SNOOP_MEM, 510, 4);
    wait_done(100);
    chk("wrap_snoops", snoop_addr_q.size(), 4);
    if (snoop_addr_q.size() == 4) begin
      chk("wrap_a0", snoop_addr_q[0], 510);
      chk("wrap_a1", snoop_addr_q[1], 511);
      chk("wrap_a2", snoop_addr_q[2], 0);
      chk("wrap_a3", snoop_addr_q[3], 1);
      chk("wrap_req", snoop_req_q[0], SNOOP_MEM);
    end
    if (id_q.size() == 4) begin
      chk("wrap_id2", id_q[2], 1000);
      chk("wrap_last", last_q[3], 1);
    end

    bus.dump_ready_i = 1'b0;
    start_cmd(SNOOP_CORE, 20, 8);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_snoops", snoop_addr_q.size(), 4);
    chk("bp_beats", id_q.size(), 0);
    chk("bp_valid", bus.dump_valid_o, 1);
    chk("bp_head_id", bus.dump_id_o, 20);
    bus.dump_ready_i = 1'b1;
    wait_done(200);
    chk("bp_beats_all", id_q.size(), 8);
    bad = 0;
    for (int i = 0; i < id_q.size(); i++) if (id_q[i] != 32'(20 + i)) bad++;
    chk("bp_order", bad, 0);
    chk("bp_err", bus.protocol_err_o, 0);
    chk("bp_dones", dones, 1);

    start_cmd(GET_EVENT_COUNTER, 77, 9);
    wait_done(100);
    chk("ctr_snoops", snoop_addr_q.size(), 1);
    if (snoop_addr_q.size() == 1) begin
      chk("ctr_addr", snoop_addr_q[0], 0);
      chk("ctr_req", snoop_req_q[0], GET_EVENT_COUNTER);
    end
    chk("ctr_beats", id_q.size(), 1);
    if (id_q.size() == 1) begin
      chk("ctr_id", id_q[0], 5);
      chk("ctr_last", last_q[0], 1);
    end

    start_cmd(SNOOP_CORE, 3, 0);
    wait_done(50);
    chk("zero_dones", dones, 1);
    chk("zero_snoops", snoop_addr_q.size(), 0);
    chk("zero_beats", id_q.size(), 0);

    start_cmd(SNOOP_CORE, 100, 1000);
    wait_done(3000);
    chk("big_beats", id_q.size(), 512);
    chk("big_snoops", snoop_addr_q.size(), 512);
    bad = 0;
    lasts = 0;
    for (int i = 0; i < id_q.size(); i++) begin
      if (id_q[i] != 32'((100 + i) % 512)) bad++;
      lasts += int'(last_q[i]);
    end
    chk("big_order", bad, 0);
    chk("big_lasts", lasts, 1);
    if (id_q.size() == 512) chk("big_final_last", last_q[511], 1);
    chk("big_err", bus.protocol_err_o, 0);

    start_cmd(SNOOP_CORE, 0, 6);
    for (int i = 0; i < 50 && id_q.size() < 2; i++) @(posedge clk);
    chk("abort_two_beats", id_q.size() >= 2, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_cmd_ready", bus.cmd_ready_o, 1);
    chk("abort_snoop_valid", bus.snoop_valid_o, 0);
    chk("abort_snoop_addr", bus.snoop_addr_o, 0);
    chk("abort_dump_valid", bus.dump_valid_o, 0);
    chk("abort_done", bus.done_o, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", dones, 0);
    chk("abort_err", bus.protocol_err_o, 0);
    chk("abort_idle", bus.cmd_ready_o, 1);

    @(posedge clk);
    #1;
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("spur_err", bus.protocol_err_o, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("spur_sticky", bus.protocol_err_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
